wb_pattern_slave: RTL



---
 rtl/wb_pattern_slave.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/wb_pattern_slave.sv
// Wishbone B3 slave that serves an incrementing byte pattern and checks writes against it.
// Adds optional wait states, linear incrementing bursts, error-address injection and mismatch counters.
module wb_pattern_slave #(
  parameter int            DW       = 32,
  parameter int            AW       = 32,
  parameter logic [7:0]    SEED     = 8'h01,
  parameter logic [7:0]    STEP     = 8'h01,
  parameter int            WAIT     = 0,
  parameter int            ERR_EN   = 0,
  parameter logic [AW-1:0] ERR_ADR  = '0,
  parameter logic [AW-1:0] ERR_MASK = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AW-1:0]     wb_adr_i,
  input  logic [DW-1:0]     wb_dat_i,
  input  logic [DW/8-1:0]   wb_sel_i,
  input  logic              wb_we_i,
  input  logic              wb_stb_i,
  input  logic              wb_cyc_i,
  input  logic [2:0]        wb_cti_i,
  input  logic [1:0]        wb_bte_i,
  output logic [DW-1:0]     wb_dat_o,
  output logic              wb_ack_o,
  output logic              wb_err_o,
  input  logic              restart_i,
  output logic              mismatch_o,
  output logic [15:0]       mismatch_cnt_o,
  output logic [31:0]       beat_cnt_o
);
  localparam int         LANES = DW / 8;
  localparam logic [7:0] ADV   = 8'(LANES * int'(STEP));

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_RESP  = 2'd2;
  localparam logic [1:0] S_BURST = 2'd3;

  logic [1:0]       state_q, state_d;
  logic             ack_q, ack_d, err_q, err_d;
  logic [3:0]       wcnt_q, wcnt_d;
  logic [7:0]       di_q, di_d;
  logic             mism_q, mism_d;
  logic [15:0]      mcnt_q, mcnt_d;
  logic [31:0]      bcnt_q, bcnt_d;
  logic [DW-1:0]    pat;
  logic [7:0]       lane_val;
  logic [LANES-1:0] lane_bad;
  logic             req, is_burst, hit_cur, hit_nxt, beat;

  function automatic logic err_hit(input logic [AW-1:0] a);
    return (ERR_EN != 0) && (((a ^ ERR_ADR) & ERR_MASK) == '0);
  endfunction

  assign req      = wb_cyc_i & wb_stb_i;
  assign is_burst = (wb_cti_i == 3'b010) && (wb_bte_i == 2'b00);
  assign hit_cur  = err_hit(wb_adr_i);
  // Back-to-back burst acks are committed before the next address is on the bus.
  assign hit_nxt  = err_hit(wb_adr_i + AW'(LANES));
  // An ack held over a master pause (stb low) is not a completed beat.
  assign beat     = ack_q & req;

  always_comb begin
    pat      = '0;
    lane_val = di_q;
    for (int k = 0; k < LANES; k++) begin
      pat[DW-8-8*k +: 8] = lane_val;
      lane_val           = lane_val + STEP;
    end
  end

  always_comb begin
    lane_bad = '0;
    for (int l = 0; l < LANES; l++)
      lane_bad[l] = wb_sel_i[l] && (wb_dat_i[8*l +: 8] != pat[8*l +: 8]);
  end

  always_comb begin
    state_d = state_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    wcnt_d  = wcnt_q;
    case (state_q)
      S_IDLE: begin
        if (req && !ack_q && !err_q) begin
          if (WAIT == 0) begin
            ack_d   = !hit_cur;
            err_d   = hit_cur;
            state_d = S_RESP;
          end else begin
            wcnt_d  = 4'(WAIT - 1);
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!req) begin
          state_d = S_IDLE;
        end else if (wcnt_q == '0) begin
          ack_d   = !hit_cur;
          err_d   = hit_cur;
          state_d = S_RESP;
        end else begin
          wcnt_d = wcnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (!err_q && req && is_burst) begin
          ack_d   = !hit_nxt;
          err_d   = hit_nxt;
          state_d = S_BURST;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        if (!wb_cyc_i || err_q) begin
          state_d = S_IDLE;
        end else if (!wb_stb_i) begin
          ack_d = 1'b0;
        end else if (ack_q) begin
          if (is_burst) begin
            ack_d = !hit_nxt;
            err_d = hit_nxt;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          ack_d = !hit_cur;
          err_d = hit_cur;
        end
      end
    endcase
  end

  always_comb begin
    di_d = di_q;
    if (restart_i)
      di_d = SEED;
    else if (beat)
      di_d = di_q + ADV;
    bcnt_d = beat ? bcnt_q + 32'd1 : bcnt_q;
    mism_d = mism_q;
    mcnt_d = mcnt_q;
    if (beat && wb_we_i && (|lane_bad)) begin
      mism_d = 1'b1;
      if (mcnt_q != 16'hFFFF)
        mcnt_d = mcnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      wcnt_q  <= '0;
      di_q    <= SEED;
      mism_q  <= 1'b0;
      mcnt_q  <= '0;
      bcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      wcnt_q  <= wcnt_d;
      di_q    <= di_d;
      mism_q  <= mism_d;
      mcnt_q  <= mcnt_d;
      bcnt_q  <= bcnt_d;
    end
  end

  assign wb_dat_o       = pat;
  assign wb_ack_o       = ack_q;
  assign wb_err_o       = err_q;
  assign mismatch_o     = mism_q;
  assign mismatch_cnt_o = mcnt_q;
  assign beat_cnt_o     = bcnt_q;
endmodule
